// File: rtl/dm_arb_pkg.sv
// ============================================================================
// Module  : dm_arb_pkg
// Purpose : Shared types and default constants for the DM port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_arb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dm_port_arbiter_if.sv
// ============================================================================
// Module  : dm_port_arbiter_if
// Purpose : Host/debug burst port bundle; master = host side, slave = arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dm_port_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [3:0]        host_len;
  logic              host_ack;
  logic              host_beat;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_done;

  modport master (
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_ack, host_beat, host_rvalid, host_rdata, host_done
  );

  modport slave (
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_ack, host_beat, host_rvalid, host_rdata, host_done
  );

endinterface

`default_nettype wire

// File: rtl/dm_arb_starve_ctr.sv
// ============================================================================
// Module  : dm_arb_starve_ctr
// Purpose : Counts blocked host-beat cycles; raises force_beat at STARVE_MAX.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_arb_starve_ctr
  import dm_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic blocked,
  input  logic beat,
  output logic force_beat
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (beat) begin
      cnt_d = '0;
    end else if (blocked && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_beat = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// ============================================================================
// Module  : dm_port_arbiter
// Purpose : Shares the data memory between the CPU DM stage (priority) and an
//           auto-incrementing host burst port. Optional guard: DM_ARB_STARVE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  dm_port_arbiter_if.slave  host,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              rd_valid_q, rd_valid_d;

  logic cpu_act, in_burst, force_raw, force_act, beat, ack, done;

  assign cpu_act   = cpu_re | cpu_we;
  assign in_burst  = (state_q == ST_BURST);
  assign force_act = in_burst & force_raw;
  assign beat      = in_burst & (~cpu_act | force_act);

`ifdef DM_ARB_STARVE_EN
  logic blocked;
  assign blocked = in_burst & cpu_act & ~force_act;

  dm_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .blocked    (blocked),
    .beat       (beat),
    .force_beat (force_raw)
  );
`else
  // Never true: without the guard the CPU keeps strict priority.
  assign force_raw = (STARVE_MAX < 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    ack        = 1'b0;
    done       = 1'b0;
    rd_valid_d = beat & ~we_q;
    case (state_q)
      ST_IDLE: begin
        if (host.host_req) begin
          ack     = 1'b1;
          we_d    = host.host_we;
          addr_d  = host.host_addr;
          cnt_d   = host.host_len;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            done    = we_q;
            state_d = we_q ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Memory strobes are held at zero while reset is asserted.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (beat) begin
        mem_re    = ~we_q;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = host.host_wdata;
      end else if (cpu_act) begin
        mem_re    = ~cpu_we;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  assign cpu_rdata        = mem_rdata;
  assign cpu_stall        = cpu_act & force_act;
  assign host.host_ack    = ack;
  assign host.host_beat   = beat;
  assign host.host_rvalid = rd_valid_q;
  assign host.host_rdata  = mem_rdata;
  assign host.host_done   = done;

endmodule

`default_nettype wire
